// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the MIPS32 core: sequences fetch/decode/execute over a shared datapath.
// Optional performance counters (instret, cycles) are built when MIPS_CTRL_PERF_EN is defined.
module mips_multicycle_ctrl #(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [31:0] instret,
  output logic [31:0] cycles
`endif
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_HALT    = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE, C_LW, C_SW, C_ADDI, C_BEQ, C_J, C_BAD
  } cls_t;

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_MAX - 1);

  state_t               state_q, state_d;
  cls_t                 cls_q, cls_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 illegal_q, illegal_d;
  logic                 bus_err_q, bus_err_d;
  state_t               ret_state;
  logic                 mem_state;

  // funct is decoded by the downstream ALU control; zero gates the PC load in the datapath.
  logic unused_inputs;
  assign unused_inputs = ^{funct, zero};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= C_RTYPE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    cnt_d     = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    ret_state = run ? S_FETCH : S_IDLE;
    mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    // Counter is zero in every non-memory state, so each memory state starts from 0.
    if (mem_state && !mem_ack) begin
      if (cnt_q == TO_LAST) begin
        bus_err_d = 1'b1;
        state_d   = S_HALT;
      end else begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
      end
    end

    case (state_q)
      S_IDLE:    if (run) state_d = S_FETCH;
      S_FETCH:   if (mem_ack) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h23:   begin cls_d = C_LW;    state_d = S_MEMADDR; end
          6'h2B:   begin cls_d = C_SW;    state_d = S_MEMADDR; end
          6'h08:   begin cls_d = C_ADDI;  state_d = S_MEMADDR; end
          6'h00:   begin cls_d = C_RTYPE; state_d = S_EXEC;    end
          6'h04:   begin cls_d = C_BEQ;   state_d = S_BRANCH;  end
          6'h02:   begin cls_d = C_J;     state_d = S_JUMP;    end
          default: begin cls_d = C_BAD;   state_d = S_HALT; illegal_d = 1'b1; end
        endcase
      end
      S_MEMADDR: begin
        case (cls_q)
          C_LW:    state_d = S_MEMRD;
          C_SW:    state_d = S_MEMWR;
          default: state_d = S_RWB;
        endcase
      end
      S_MEMRD:   if (mem_ack) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ack) state_d = ret_state;
      S_EXEC:    state_d = S_RWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP: state_d = ret_state;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_HALT;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
      end
      S_DECODE:  alu_src_b = 2'd3;
      S_MEMADDR: begin alu_src_a = 1'b1; alu_src_b = 2'd2; end
      S_MEMRD:   begin mem_req = 1'b1; iord = 1'b1; end
      S_MEMWB:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      S_MEMWR:   begin mem_req = 1'b1; mem_we = 1'b1; iord = 1'b1; end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        reg_dst   = (cls_q == C_RTYPE);
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = (cls_q == C_RTYPE);
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
      end
      S_JUMP:  begin pc_write = 1'b1; pc_source = 2'd2; end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign state   = state_q;

`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] instret_q, instret_d;
  logic [31:0] cycles_q, cycles_d;
  logic        retire;

  always_comb begin
    retire    = (state_q == S_MEMWB) || (state_q == S_RWB) || (state_q == S_BRANCH) ||
                (state_q == S_JUMP) || ((state_q == S_MEMWR) && mem_ack);
    instret_d = retire ? instret_q + 32'd1 : instret_q;
    cycles_d  = ((state_q != S_IDLE) && (state_q != S_HALT)) ? cycles_q + 32'd1 : cycles_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
      cycles_q  <= '0;
    end else begin
      instret_q <= instret_d;
      cycles_q  <= cycles_d;
    end
  end

  assign instret = instret_q;
  assign cycles  = cycles_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: expected control vectors are queued per step and checked
// against the DUT half a cycle later.
module tb_mips_multicycle_ctrl;
  localparam int W = 22;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_FETCH   = 4'd1;
  localparam logic [3:0] ST_DECODE  = 4'd2;
  localparam logic [3:0] ST_MEMADDR = 4'd3;
  localparam logic [3:0] ST_MEMRD   = 4'd4;
  localparam logic [3:0] ST_MEMWB   = 4'd5;
  localparam logic [3:0] ST_MEMWR   = 4'd6;
  localparam logic [3:0] ST_EXEC    = 4'd7;
  localparam logic [3:0] ST_RWB     = 4'd8;
  localparam logic [3:0] ST_BRANCH  = 4'd9;
  localparam logic [3:0] ST_JUMP    = 4'd10;
  localparam logic [3:0] ST_HALT    = 4'd15;

  logic       clk = 1'b0;
  logic       rst_n, run, zero, mem_ack;
  logic [5:0] opcode, funct;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal, bus_err;
  logic [3:0] state;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] instret, cycles;
  logic [31:0] exp_instret, exp_cycles;
`endif

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  logic         ill_e, be_e;
  logic [W-1:0] obs;

  mips_multicycle_ctrl #(.TIMEOUT_W(8), .TIMEOUT_MAX(255)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal), .bus_err(bus_err),
    .state(state)
`ifdef MIPS_CTRL_PERF_EN
    , .instret(instret), .cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  assign obs = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source,
                alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal, bus_err};

  // Control-word table: what each state must drive.
  function automatic logic [W-1:0] spec_out(input logic [3:0] st, input logic ack,
                                            input logic rd, input logic ill, input logic be);
    logic req, we, io, irw, pcw, pcwc, asa, rw, rdo, m2r;
    logic [1:0] pcs, asb, aop;
    {req, we, io, irw, pcw, pcwc, asa, rw, rdo, m2r} = '0;
    {pcs, asb, aop} = '0;
    case (st)
      ST_FETCH:   begin req = 1; asb = 2'd1; irw = ack; pcw = ack; end
      ST_DECODE:  asb = 2'd3;
      ST_MEMADDR: begin asa = 1; asb = 2'd2; end
      ST_MEMRD:   begin req = 1; io = 1; end
      ST_MEMWB:   begin rw = 1; m2r = 1; end
      ST_MEMWR:   begin req = 1; we = 1; io = 1; end
      ST_EXEC:    begin asa = 1; aop = 2'd2; rdo = rd; end
      ST_RWB:     begin rw = 1; rdo = rd; end
      ST_BRANCH:  begin asa = 1; aop = 2'd1; pcwc = 1; pcs = 2'd1; end
      ST_JUMP:    begin pcw = 1; pcs = 2'd2; end
      default:    ;
    endcase
    return {st, req, we, io, irw, pcw, pcwc, pcs, asa, asb, aop, rw, rdo, m2r, ill, be};
  endfunction

  task automatic check_now(input logic [3:0] st, input logic ack, input logic rd, input string tag);
    logic [W-1:0] e;
    string t;
    exp_q.push_back(spec_out(st, ack, rd, ill_e, be_e));
    tag_q.push_back(tag);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
`ifdef MIPS_CTRL_PERF_EN
    n_cmp++;
    assert (instret === exp_instret) else begin
      n_fail++;
      $error("FAIL %s_instret: observed %0d expected %0d", t, instret, exp_instret);
    end
    n_cmp++;
    assert (cycles === exp_cycles) else begin
      n_fail++;
      $error("FAIL %s_cycles: observed %0d expected %0d", t, cycles, exp_cycles);
    end
    if (st == ST_MEMWB || st == ST_RWB || st == ST_BRANCH || st == ST_JUMP ||
        (st == ST_MEMWR && ack))
      exp_instret = exp_instret + 32'd1;
    if (st != ST_IDLE && st != ST_HALT)
      exp_cycles = exp_cycles + 32'd1;
`endif
  endtask

  task automatic step(input logic [3:0] st, input logic ack, input logic rd, input string tag);
    @(negedge clk);
    mem_ack = ack;
    check_now(st, ack, rd, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    ill_e   = 1'b0;
    be_e    = 1'b0;
`ifdef MIPS_CTRL_PERF_EN
    exp_instret = '0;
    exp_cycles  = '0;
`endif
    check_now(ST_IDLE, 1'b0, 1'b0, tag);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_now(ST_IDLE, 1'b0, 1'b0, "release_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; run = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ack = 1'b0;
    ill_e = 1'b0; be_e = 1'b0;
`ifdef MIPS_CTRL_PERF_EN
    exp_instret = '0;
    exp_cycles  = '0;
`endif
    do_reset("reset_state");
    step(ST_FETCH, 0, 0, "fetch_req");

    // R-type add
    opcode = 6'h00; funct = 6'h20;
    step(ST_FETCH, 1, 0, "add_fetch_ack");
    step(ST_DECODE, 0, 0, "add_decode");
    step(ST_EXEC, 1, 1, "add_exec_ack_ignored");
    step(ST_RWB, 0, 1, "add_rwb");
    step(ST_FETCH, 0, 0, "add_next_req");

    // lw with three stalled memory cycles
    opcode = 6'h23;
    step(ST_FETCH, 1, 0, "lw_fetch_ack");
    step(ST_DECODE, 0, 0, "lw_decode");
    step(ST_MEMADDR, 0, 0, "lw_memaddr");
    for (int i = 0; i < 3; i++) step(ST_MEMRD, 0, 0, "lw_memrd_wait");
    step(ST_MEMRD, 1, 0, "lw_memrd_ack");
    step(ST_MEMWB, 0, 0, "lw_memwb");
    step(ST_FETCH, 0, 0, "lw_next");

    // sw, addi
    opcode = 6'h2B;
    step(ST_FETCH, 1, 0, "sw_fetch_ack");
    step(ST_DECODE, 0, 0, "sw_decode");
    step(ST_MEMADDR, 0, 0, "sw_memaddr");
    step(ST_MEMWR, 1, 0, "sw_memwr_ack");
    step(ST_FETCH, 0, 0, "sw_next");
    opcode = 6'h08;
    step(ST_FETCH, 1, 0, "addi_fetch_ack");
    step(ST_DECODE, 0, 0, "addi_decode");
    step(ST_MEMADDR, 0, 0, "addi_memaddr");
    step(ST_RWB, 0, 0, "addi_rwb");
    step(ST_FETCH, 0, 0, "addi_next");

    // beq taken and not taken drive identical strobes
    opcode = 6'h04; zero = 1'b1;
    step(ST_FETCH, 1, 0, "beq1_fetch_ack");
    step(ST_DECODE, 0, 0, "beq1_decode");
    step(ST_BRANCH, 0, 0, "beq1_branch");
    zero = 1'b0;
    step(ST_FETCH, 1, 0, "beq0_fetch_ack");
    step(ST_DECODE, 0, 0, "beq0_decode");
    step(ST_BRANCH, 0, 0, "beq0_branch");
    step(ST_FETCH, 0, 0, "beq0_next");

    // j with run dropped mid-instruction: takes effect only at the boundary
    opcode = 6'h02;
    step(ST_FETCH, 1, 0, "j_fetch_ack");
    run = 1'b0;
    step(ST_DECODE, 1, 0, "j_decode_ack_ignored");
    step(ST_JUMP, 0, 0, "j_jump");
    step(ST_IDLE, 0, 0, "j_to_idle");
    step(ST_IDLE, 1, 0, "idle_hold");
    run = 1'b1;
    step(ST_FETCH, 0, 0, "idle_to_fetch");

    // illegal opcode halts for good
    opcode = 6'h3F;
    step(ST_FETCH, 1, 0, "ill_fetch_ack");
    step(ST_DECODE, 0, 0, "ill_decode");
    ill_e = 1'b1;
    for (int i = 0; i < 20; i++) step(ST_HALT, (i == 5), 0, "ill_halt");

    // reset in the middle of a load drops mem_req at once
    do_reset("reset_from_halt");
    opcode = 6'h23;
    step(ST_FETCH, 1, 0, "mid_fetch_ack");
    step(ST_DECODE, 0, 0, "mid_decode");
    step(ST_MEMADDR, 0, 0, "mid_memaddr");
    step(ST_MEMRD, 0, 0, "mid_memrd");
    do_reset("reset_mid_memrd");

    // fetch timeout: 255 cycles without ack then HALT with bus_err
    for (int i = 0; i < 255; i++) step(ST_FETCH, 0, 0, "to_fetch_wait");
    be_e = 1'b1;
    step(ST_HALT, 0, 0, "to_halt_bus_err");
    step(ST_HALT, 1, 0, "to_halt_stays");

    // ack on the last allowed cycle wins over the timeout
    do_reset("reset_from_timeout");
    opcode = 6'h00;
    for (int i = 0; i < 254; i++) step(ST_FETCH, 0, 0, "edge_fetch_wait");
    step(ST_FETCH, 1, 0, "edge_ack_wins");
    step(ST_DECODE, 0, 0, "edge_decode");
    step(ST_EXEC, 0, 1, "edge_exec");
    step(ST_RWB, 0, 1, "edge_rwb");
    step(ST_FETCH, 0, 0, "edge_next");

    // add, sw, j with single-cycle acks
    opcode = 6'h00;
    step(ST_FETCH, 1, 0, "p_add_fetch");
    step(ST_DECODE, 0, 0, "p_add_decode");
    step(ST_EXEC, 0, 1, "p_add_exec");
    step(ST_RWB, 0, 1, "p_add_rwb");
    opcode = 6'h2B;
    step(ST_FETCH, 1, 0, "p_sw_fetch");
    step(ST_DECODE, 0, 0, "p_sw_decode");
    step(ST_MEMADDR, 0, 0, "p_sw_memaddr");
    step(ST_MEMWR, 1, 0, "p_sw_memwr");
    opcode = 6'h02;
    step(ST_FETCH, 1, 0, "p_j_fetch");
    run = 1'b0;
    step(ST_DECODE, 0, 0, "p_j_decode");
    step(ST_JUMP, 0, 0, "p_j_jump");
    step(ST_IDLE, 0, 0, "p_idle");
    step(ST_IDLE, 0, 0, "p_idle_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle control FSM for the MIPS32 core.
- Consumes the opcode/funct fields split from the instruction register and sequences the shared datapath: PC, IR, a single unified memory port, register file, and ALU.
- Issues per-state control strobes and runs a req/ack memory handshake with a timeout.
- Sits between the field splitter and the datapath muxes/enables.

Parameters:
- TIMEOUT_W, 8, width of the memory-wait counter.
- TIMEOUT_MAX, 255, number of cycles waited for mem_ack before a bus error is flagged. Must be ≥1 and fit in TIMEOUT_W bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; while high the FSM leaves IDLE and fetches
- opcode  in  6  instr[31:26] from the split IR
- funct  in  6  instr[5:0] from the split IR
- zero  in  1  ALU zero flag, used for beq
- mem_ack  in  1  one-cycle memory completion pulse
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write qualifier for mem_req
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- ir_write  out  1  load IR
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- pc_source  out  2  0 = ALU, 1 = ALUOut, 2 = jump target
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2
- alu_op  out  2  0 = add, 1 = sub, 2 = decode funct
- reg_write  out  1  register-file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- illegal  out  1  sticky illegal-opcode flag
- bus_err  out  1  sticky memory-timeout flag
- state  out  4  current state encoding, for debug

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all strobes 0, illegal=0, bus_err=0, timeout counter=0. Reset mid-transaction drops mem_req immediately; no partial writeback occurs.
- All control outputs are Moore outputs, decoded from the registered state. Opcode and funct are sampled only in DECODE and latched into an internal class register.
- States (encoding 0..10): IDLE, FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP; plus HALT = 15.
- IDLE: run=1 → FETCH.
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0.
  - On mem_ack: ir_write=1 and pc_write=1, pc_source=0, in that same cycle → DECODE.
- DECODE: alu_src_a=0, alu_src_b=3 (branch target precompute). Next state by opcode:
  - 0x23 (lw), 0x2B (sw), 0x08 (addi) → MEMADDR
  - 0x00 (R-type) → EXEC
  - 0x04 (beq) → BRANCH
  - 0x02 (j) → JUMP
  - any other opcode → HALT, with illegal set.
- MEMADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Next: lw → MEMRD, sw → MEMWR, addi → RWB with the immediate path selected (reg_dst=0, mem_to_reg=0).
- MEMRD: mem_req=1, iord=1; mem_ack → MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; → FETCH, or → IDLE if run=0.
- MEMWR: mem_req=1, mem_we=1, iord=1; mem_ack → FETCH/IDLE.
- EXEC: alu_src_a=1, alu_src_b=0, alu_op=2 → RWB. reg_dst=1 for R-type, 0 for addi.
- RWB: reg_write=1, mem_to_reg=0; → FETCH/IDLE.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1; → FETCH/IDLE.
- JUMP: pc_write=1, pc_source=2; → FETCH/IDLE.
- HALT: all strobes 0; exit only via reset.
- Return rule: every instruction-final state goes to FETCH if run=1, else IDLE. run only takes effect at instruction boundaries.
- Memory handshake:
  - mem_req stays high in FETCH, MEMRD and MEMWR until a cycle with mem_ack=1.
  - mem_ack outside those states is ignored.
- Timeout counter:
  - Clears on entry to each memory state and increments every cycle without ack.
  - If it reaches TIMEOUT_MAX with no ack: bus_err=1 and next state = HALT.
  - If ack arrives in the same cycle the count reaches TIMEOUT_MAX, ack wins.

Optional Feature:
- Macro MIPS_CTRL_PERF_EN.
- Defined: adds output instret[31:0] and output cycles[31:0].
  - instret increments once per instruction-final state exit (MEMWB, MEMWR-ack, RWB, BRANCH, JUMP).
  - cycles increments every clock outside IDLE/HALT.
  - Both reset to 0, wrap 0xFFFFFFFF→0, and freeze in HALT.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset with run=1: hold rst_n=0 for 3 clocks, release → state=IDLE(0) for 1 cycle, then FETCH with mem_req=1, iord=0; all other strobes 0.
- R-type add: ack in FETCH cycle 1, opcode=0x00, funct=0x20 → DECODE → EXEC (alu_op=2) → RWB (reg_write=1, reg_dst=1) → FETCH; 4 cycles from ack to the next mem_req.
- lw with ack delayed 3 cycles in MEMRD: opcode=0x23 → mem_req held 3 cycles with iord=1, then MEMWB (mem_to_reg=1, reg_write=1) → FETCH.
- beq: opcode=0x04, zero=1 → BRANCH asserts pc_write_cond=1, pc_source=1, alu_op=1; repeat with zero=0 → the same strobes (the datapath gates the PC load).
- Illegal and timeout:
  - opcode=0x3F → HALT, illegal=1, strobes stay 0 for 20 cycles despite run=1.
  - After reset, no ack in FETCH → bus_err=1 after exactly 255 cycles, then HALT.
- MIPS_CTRL_PERF_EN build: run 3 instructions (add, sw, j) with 1-cycle acks → instret=3; cycles equals the elapsed non-IDLE clocks.
